// File: rtl/multi_phase_pwm_pkg.sv
// Shared types and default sizing for the multi-phase PWM block.
package pwm_pkg;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_e;

   localparam int PWM_CNT_W_DEF    = 32;
   localparam int PWM_CHANNELS_DEF = 3;
   localparam int PWM_DT_W_DEF     = 10;

endpackage

// File: rtl/multi_phase_pwm_if.sv
// Register-file side bundle of the PWM block; DeadTime/PWM_N exist only
// when PWM_DEADTIME_EN is defined.
interface multi_phase_pwm_if #(
   parameter int CHANNELS = 3,
   parameter int CNT_W    = 32,
   parameter int DT_W     = 10
);

   logic [CNT_W-1:0]          Period;
   logic [CHANNELS*CNT_W-1:0] Duty;
   logic                      Enable;
   logic                      CenterAligned;
   logic                      Interrupt_Enable;
   logic                      Interrupt_Clear;
   logic [CHANNELS-1:0]       PWM;
   logic                      Cycle_Start;
   logic                      Interrupt_Active;

   if (DT_W < 1) begin : g_dt_w_invalid
   end

`ifdef PWM_DEADTIME_EN
   logic [DT_W-1:0]     DeadTime;
   logic [CHANNELS-1:0] PWM_N;

   modport master (
      output Period, Duty, Enable, CenterAligned, Interrupt_Enable, Interrupt_Clear, DeadTime,
      input  PWM, Cycle_Start, Interrupt_Active, PWM_N
   );
   modport slave (
      input  Period, Duty, Enable, CenterAligned, Interrupt_Enable, Interrupt_Clear, DeadTime,
      output PWM, Cycle_Start, Interrupt_Active, PWM_N
   );
`else
   modport master (
      output Period, Duty, Enable, CenterAligned, Interrupt_Enable, Interrupt_Clear,
      input  PWM, Cycle_Start, Interrupt_Active
   );
   modport slave (
      input  Period, Duty, Enable, CenterAligned, Interrupt_Enable, Interrupt_Clear,
      output PWM, Cycle_Start, Interrupt_Active
   );
`endif

endinterface

// File: rtl/multi_phase_pwm_deadtime.sv
// Per-channel dead-time inserter (built only with PWM_DEADTIME_EN): rising
// edges of PWM and PWM_N are held off for dt_i cycles, falling edges pass.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime #(
   parameter int DT_W = 10
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            en_i,
   input  logic            raw_i,
   input  logic [DT_W-1:0] dt_i,
   output logic            pwm_o,
   output logic            pwm_n_o
);

   logic            raw_q;
   logic [DT_W-1:0] cnt_q, cnt_d;
   logic [DT_W-1:0] rem;
   logic            open;
   logic            pwm_q, pwm_d;
   logic            pwm_n_q, pwm_n_d;

   // Any edge of raw restarts the hold-off, so pulses shorter than dt vanish.
   always_comb begin
      rem     = (raw_i != raw_q) ? dt_i : cnt_q;
      open    = (rem == '0);
      cnt_d   = open ? '0 : rem - 1'b1;
      pwm_d   = raw_i & open;
      pwm_n_d = en_i & ~raw_i & open;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         raw_q   <= 1'b0;
         cnt_q   <= '0;
         pwm_q   <= 1'b0;
         pwm_n_q <= 1'b0;
      end else begin
         raw_q   <= raw_i;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_d;
         pwm_n_q <= pwm_n_d;
      end
   end

   assign pwm_o   = pwm_q;
   assign pwm_n_o = pwm_n_q;

endmodule
`endif

// File: rtl/multi_phase_pwm.sv
// N-channel edge/center-aligned PWM with shadowed period/duty/mode and a
// boundary interrupt; PWM_DEADTIME_EN adds complementary dead-time outputs.
module multi_phase_pwm
   import pwm_pkg::*;
#(
   parameter int CHANNELS = PWM_CHANNELS_DEF,
   parameter int CNT_W    = PWM_CNT_W_DEF,
   parameter int DT_W     = PWM_DT_W_DEF
) (
   input logic        Clk,
   input logic        Reset,
   multi_phase_pwm_if.slave bus
);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   pwm_dir_e            dir_q, dir_d;
   logic [CNT_W-1:0]    per_sh_q, per_sh_d;
   logic [CNT_W-1:0]    duty_sh_q [CHANNELS];
   logic [CNT_W-1:0]    duty_sh_d [CHANNELS];
   pwm_mode_e           mode_sh_q, mode_sh_d;
   pwm_mode_e           mode_in;
   logic [CHANNELS-1:0] raw;
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                cs_q;
   logic                irq_q, irq_d;
   logic                bnd;
   logic                load;

   function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] p);
      return (d > p) ? p : d;
   endfunction

   if (DT_W < 1) begin : g_dt_w_invalid
   end

   assign mode_in = bus.CenterAligned ? PWM_CENTER : PWM_EDGE;

   always_comb begin
      bnd = 1'b0;
      if (bus.Enable) begin
         if (mode_sh_q == PWM_EDGE) bnd = (cnt_q >= per_sh_q);
         else                       bnd = (cnt_q == '0) && ((dir_q == DIR_DOWN) || (per_sh_q == '0));
      end
   end

   assign load = !bus.Enable || bnd;

   // Leaving a center valley into another center period skips straight to 1 so
   // the period stays 2P; every other boundary restarts from 0 counting up.
   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!bus.Enable) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (bnd) begin
         dir_d = DIR_UP;
         cnt_d = (mode_sh_q == PWM_CENTER && mode_in == PWM_CENTER && bus.Period != '0)
                 ? CNT_W'(1) : '0;
      end else if (mode_sh_q == PWM_EDGE) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dir_q == DIR_UP) begin
         if (cnt_q >= per_sh_q) begin
            cnt_d = per_sh_q - 1'b1;
            dir_d = DIR_DOWN;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_comb begin
      per_sh_d  = load ? bus.Period : per_sh_q;
      mode_sh_d = load ? mode_in : mode_sh_q;
      for (int i = 0; i < CHANNELS; i++) begin
         duty_sh_d[i] = load ? clamp_duty(bus.Duty[i*CNT_W +: CNT_W], bus.Period) : duty_sh_q[i];
      end
   end

   // Center threshold is inclusive on the way up and exclusive on the way down,
   // giving exactly 2*Duty high cycles per 2P-cycle period.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (duty_sh_q[i] == '0)                raw[i] = 1'b0;
         else if (duty_sh_q[i] >= per_sh_q)     raw[i] = 1'b1;
         else if (mode_sh_q == PWM_EDGE)        raw[i] = (cnt_q < duty_sh_q[i]);
         else if (dir_q == DIR_UP)              raw[i] = (cnt_q >= per_sh_q - duty_sh_q[i]);
         else                                   raw[i] = (cnt_q >  per_sh_q - duty_sh_q[i]);
      end
      pwm_d = bus.Enable ? raw : '0;
   end

   always_comb begin
      irq_d = irq_q;
      if (bnd && bus.Interrupt_Enable) irq_d = 1'b1;
      else if (bus.Interrupt_Clear)    irq_d = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q     <= '0;
         dir_q     <= DIR_UP;
         per_sh_q  <= '0;
         mode_sh_q <= PWM_EDGE;
         for (int i = 0; i < CHANNELS; i++) duty_sh_q[i] <= '0;
         pwm_q     <= '0;
         cs_q      <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         per_sh_q  <= per_sh_d;
         mode_sh_q <= mode_sh_d;
         for (int i = 0; i < CHANNELS; i++) duty_sh_q[i] <= duty_sh_d[i];
         pwm_q     <= pwm_d;
         cs_q      <= bnd;
         irq_q     <= irq_d;
      end
   end

   assign bus.Cycle_Start      = cs_q;
   assign bus.Interrupt_Active = irq_q;

`ifdef PWM_DEADTIME_EN
   logic                en_q;
   logic [CHANNELS-1:0] pwm_dt, pwm_n_dt;

   // Enable delayed to line up with pwm_q feeding the dead-time stage.
   always_ff @(posedge Clk) begin
      if (Reset) en_q <= 1'b0;
      else       en_q <= bus.Enable;
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_dt
      pwm_deadtime #(.DT_W(DT_W)) u_dt (
         .Clk     (Clk),
         .Reset   (Reset),
         .en_i    (en_q),
         .raw_i   (pwm_q[g]),
         .dt_i    (bus.DeadTime),
         .pwm_o   (pwm_dt[g]),
         .pwm_n_o (pwm_n_dt[g])
      );
   end

   assign bus.PWM   = pwm_dt;
   assign bus.PWM_N = pwm_n_dt;
`else
   assign bus.PWM = pwm_q;
`endif

endmodule

// File: tb/tb_multi_phase_pwm.sv
// Scoreboard bench for multi_phase_pwm: per-period pulse widths are queued by
// the stimulus and checked by a monitor at each Cycle_Start window.
module tb_multi_phase_pwm;

   localparam int CH = 3;
   localparam int CW = 16;
   localparam int DW = 6;

   typedef struct packed {
      logic [15:0]          len;
      logic [CH-1:0][15:0]  hi;
      logic [CH-1:0][15:0]  hin;
      logic                 chk_n;
   } rec_t;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   multi_phase_pwm_if #(.CHANNELS(CH), .CNT_W(CW), .DT_W(DW)) bus ();

   multi_phase_pwm #(.CHANNELS(CH), .CNT_W(CW), .DT_W(DW)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: a window runs from just after one Cycle_Start up to and
   // including the next, which maps onto one full counter period.
   int acc_len;
   int acc_hi  [CH];
   int acc_hin [CH];
   int acc_ovl;
`ifdef PWM_DEADTIME_EN
   logic cs_prev = 1'b0;
`endif

   initial begin
      acc_len = 0;
      acc_ovl = 0;
      for (int i = 0; i < CH; i++) begin
         acc_hi[i]  = 0;
         acc_hin[i] = 0;
      end
   end

   always @(negedge Clk) begin
      logic close;
      rec_t r;
      acc_len++;
      for (int i = 0; i < CH; i++) begin
         acc_hi[i] += int'(bus.PWM[i]);
`ifdef PWM_DEADTIME_EN
         acc_hin[i] += int'(bus.PWM_N[i]);
         acc_ovl    += int'(bus.PWM[i] & bus.PWM_N[i]);
`endif
      end
`ifdef PWM_DEADTIME_EN
      close   = cs_prev;
      cs_prev = bus.Cycle_Start;
`else
      close = bus.Cycle_Start;
`endif
      if (close && !Reset) begin
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("win_len", acc_len, int'(r.len));
            for (int i = 0; i < CH; i++)
               chk($sformatf("win_hi_ch%0d", i), acc_hi[i], int'(r.hi[i]));
            if (r.chk_n) begin
               for (int i = 0; i < CH; i++)
                  chk($sformatf("win_hin_ch%0d", i), acc_hin[i], int'(r.hin[i]));
               chk("win_overlap", acc_ovl, 0);
            end
         end
      end
      if (close || Reset) begin
         acc_len = 0;
         acc_ovl = 0;
         for (int i = 0; i < CH; i++) begin
            acc_hi[i]  = 0;
            acc_hin[i] = 0;
         end
      end
   end

   task automatic set_cfg(input int p, input int d0, input int d1, input int d2, input bit center);
      bus.Period        = CW'(p);
      bus.Duty          = {CW'(d2), CW'(d1), CW'(d0)};
      bus.CenterAligned = center;
   endtask

   task automatic push(input int len, input int h0, input int h1, input int h2,
                       input int n0, input int n1, input int n2);
      rec_t r;
      r.len    = 16'(len);
      r.hi[0]  = 16'(h0);
      r.hi[1]  = 16'(h1);
      r.hi[2]  = 16'(h2);
      r.hin[0] = 16'(n0);
      r.hin[1] = 16'(n1);
      r.hin[2] = 16'(n2);
`ifdef PWM_DEADTIME_EN
      r.chk_n  = 1'b1;
`else
      r.chk_n  = 1'b0;
`endif
      exp_q.push_back(r);
   endtask

   // Returns at the negedge where Cycle_Start is seen.
   task automatic wait_cs();
      bit seen;
      seen = 1'b0;
      @(posedge Clk);
      for (int n = 0; n < 200; n++) begin
         @(negedge Clk);
         if (bus.Cycle_Start) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL cycle_start_timeout: got none expected pulse within 200 cycles");
      end
   endtask

   // Returns after the monitor has closed the window ending at this pulse.
   task automatic sync_cs();
      wait_cs();
`ifdef PWM_DEADTIME_EN
      @(negedge Clk);
`endif
      @(posedge Clk);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && exp_q.size() > 0; n++) @(negedge Clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending windows expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      Reset                = 1'b1;
      bus.Enable           = 1'b0;
      bus.Interrupt_Enable = 1'b0;
      bus.Interrupt_Clear  = 1'b0;
      set_cfg(0, 0, 0, 0, 1'b0);
`ifdef PWM_DEADTIME_EN
      bus.DeadTime = '0;
`endif
      repeat (3) @(negedge Clk);
      chk("rst_pwm", int'(bus.PWM), 0);
      chk("rst_cycle_start", int'(bus.Cycle_Start), 0);
      chk("rst_irq", int'(bus.Interrupt_Active), 0);
`ifdef PWM_DEADTIME_EN
      chk("rst_pwm_n", int'(bus.PWM_N), 0);
`endif

      // Edge mode P=9, duties 0/5/9.
      Reset = 1'b0;
      set_cfg(9, 0, 5, 9, 1'b0);
      bus.Enable = 1'b1;
      sync_cs();
      sync_cs();
      repeat (3) push(10, 0, 5, 10, 10, 5, 0);
      drain();

      // Center mode P=8, duties 4/0/8.
      @(negedge Clk);
      set_cfg(8, 4, 0, 8, 1'b1);
      sync_cs();
      sync_cs();
      repeat (2) push(16, 8, 0, 16, 8, 16, 0);
      drain();

      // Duty 3 -> 7 mid-period: current period keeps width 3.
      @(negedge Clk);
      set_cfg(9, 3, 5, 9, 1'b0);
      sync_cs();
      sync_cs();
      push(10, 3, 5, 10, 7, 5, 0);
      repeat (4) @(negedge Clk);
      set_cfg(9, 7, 5, 9, 1'b0);
      push(10, 7, 5, 10, 3, 5, 0);
      drain();

      // Duty beyond period clamps to always-high.
      @(negedge Clk);
      set_cfg(9, 20, 9, 0, 1'b0);
      sync_cs();
      sync_cs();
      repeat (2) push(10, 10, 10, 0, 0, 0, 10);
      drain();

      // Zero period: boundary every cycle, outputs low.
      @(negedge Clk);
      set_cfg(0, 5, 0, 0, 1'b0);
      sync_cs();
      sync_cs();
      repeat (4) push(1, 0, 0, 0, 1, 1, 1);
      drain();

      // Interrupt set/clear interplay.
      @(negedge Clk);
      set_cfg(9, 5, 5, 5, 1'b0);
      bus.Interrupt_Enable = 1'b1;
      bus.Interrupt_Clear  = 1'b1;
      wait_cs();
      chk("irq_set_wins_over_clear", int'(bus.Interrupt_Active), 1);
      @(negedge Clk);
      chk("irq_cleared_after_boundary", int'(bus.Interrupt_Active), 0);
      bus.Interrupt_Clear = 1'b0;
      wait_cs();
      chk("irq_set_at_boundary", int'(bus.Interrupt_Active), 1);
      bus.Interrupt_Enable = 1'b0;
      repeat (12) @(negedge Clk);
      chk("irq_sticky", int'(bus.Interrupt_Active), 1);
      bus.Interrupt_Clear = 1'b1;
      @(negedge Clk);
      chk("irq_clear", int'(bus.Interrupt_Active), 0);
      repeat (12) @(negedge Clk);
      chk("irq_clear_when_idle", int'(bus.Interrupt_Active), 0);
      bus.Interrupt_Clear = 1'b0;
      wait_cs();
      chk("irq_disarmed_boundary", int'(bus.Interrupt_Active), 0);

      // Reset asserted while channel pulses are high.
      bus.Interrupt_Enable = 1'b1;
      wait_cs();
      repeat (3) @(negedge Clk);
      chk("pwm_high_before_reset", int'(bus.PWM), 7);
      Reset = 1'b1;
      @(negedge Clk);
      chk("midreset_pwm", int'(bus.PWM), 0);
      chk("midreset_cycle_start", int'(bus.Cycle_Start), 0);
      chk("midreset_irq", int'(bus.Interrupt_Active), 0);
      Reset                = 1'b0;
      bus.Interrupt_Enable = 1'b0;
      sync_cs();
      sync_cs();
      push(10, 5, 5, 5, 5, 5, 5);
      drain();

`ifdef PWM_DEADTIME_EN
      // Dead-time 3, edge P=19, duty 10 on all channels.
      @(negedge Clk);
      bus.DeadTime = DW'(3);
      set_cfg(19, 10, 10, 10, 1'b0);
      sync_cs();
      sync_cs();
      repeat (2) push(20, 7, 7, 7, 7, 7, 7);
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion expected finish before 200000");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/multi_phase_pwm.md
# multi_phase_pwm

Parametrised N-channel PWM generator, the successor to the fixed three-phase block. It supports configurable counter width and channel count, true up/down center-aligned counting, and shadowed period/duty registers that update glitch-free at a cycle boundary. It also provides a boundary interrupt and optional complementary outputs with dead-time insertion. It sits between the motor-control register file and the gate-driver pins.

## Interface
- CHANNELS, 3, number of PWM channels (1..16)
- CNT_W, 32, counter/period/duty width in bits (8..32)
- DT_W, 10, dead-time counter width (used only when dead-time is compiled in)
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Period  in  CNT_W  terminal count P (live value, shadowed)
- Duty  in  CHANNELS*CNT_W  per-channel compare; channel i at [i*CNT_W +: CNT_W] (shadowed)
- Enable  in  1  run counter and outputs
- CenterAligned  in  1  0 = edge (sawtooth), 1 = center (triangle); shadowed
- PWM  out  CHANNELS  channel outputs, registered
- Cycle_Start  out  1  one-cycle pulse at each shadow-load boundary
- Interrupt_Enable  in  1  arm interrupt set at boundary
- Interrupt_Clear  in  1  clear pending interrupt
- Interrupt_Active  out  1  sticky interrupt flag
- DeadTime  in  DT_W  dead-time in Clk cycles (only with PWM_DEADTIME_EN)
- PWM_N  out  CHANNELS  complementary outputs (only with PWM_DEADTIME_EN)

## Operation
- Shadow set: Period_sh, Duty_sh[i], Mode_sh; each Duty clamped to Period at load time.
- Boundary event B: edge mode when count == Period_sh; center mode when count == 0 while counting down (valley), or when count == 0 and Period_sh == 0.
- At B: shadows load from live inputs; Cycle_Start = 1 next cycle; Interrupt_Active <= 1 if Interrupt_Enable.
- Edge mode: count 0..P, wraps to 0 (P+1 cycles per period). Raw[i] = count < Duty_sh[i].
- Center mode: count 0 up to P, then P down to 0; direction flips at P and at 0 (2P cycles per period). Raw[i] = count >= P - Duty_sh[i].
- Duty_sh == 0: constant low. Duty_sh == Period_sh (P > 0): constant high for the whole period.
- Period_sh == 0: count held at 0, B every cycle, PWM low.
- Enable low: count held at 0, direction up, PWM/PWM_N low, shadows load every cycle. On the first Enable-high cycle, counting starts from 0 up using the values loaded the previous cycle.
- Interrupt: set and clear in the same cycle → set wins. Clear has no effect on an idle flag.
- Mode change takes effect only at B. The counter direction resets to up on a mode load.

## Timing
- Reset values: count 0, direction up, all shadows 0, PWM 0, PWM_N 0, Cycle_Start 0, Interrupt_Active 0.
- PWM[i] is registered from the compare on the current count: 1-cycle latency from count to pin.
- Live input change → visible on PWM no earlier than B + 2 cycles. Changes mid-period never alter the current period.
- Reset asserted mid-period: all outputs are 0 on the next edge; there is no partial pulse afterwards.
- With dead-time: add 1 further register stage (PWM latency 2 from count).

## Configuration
- PWM_DEADTIME_EN defined:
  - PWM_N ports and DeadTime input exist.
  - Per channel, rising edge of PWM delayed by DeadTime cycles; rising edge of PWM_N (= ~raw) likewise delayed; falling edges immediate.
  - PWM and PWM_N are never high together.
  - DeadTime 0 → PWM_N = ~PWM while enabled.
  - Pulses shorter than DeadTime are swallowed.
- PWM_DEADTIME_EN not defined: no PWM_N/DeadTime ports; PWM driven directly from the compare register.

## Structure
- Package pwm_pkg: pwm_mode_e {PWM_EDGE, PWM_CENTER}, direction enum, default CNT_W/CHANNELS/DT_W constants.
- Sub-module pwm_deadtime (one per channel via generate, compiled only under PWM_DEADTIME_EN): raw in, PWM/PWM_N out, DT_W down-counter.
- Counter, shadows and compare stay in the top module.

## Test plan
- Edge mode, P=9, Duty={0,5,9}: ch0 always low; ch1 high 5 of 10 cycles; ch2 high throughout; Cycle_Start every 10 cycles.
- Center mode, P=8, Duty[0]=4: count 0→8→0, period 16; PWM high for 8 cycles centred on count 8.
- Duty[0] changed 3→7 mid-period (edge, P=9): current period keeps a width of 3; next period has a width of 7.
- Duty=20 with P=9: clamped, PWM constant high; P=0: PWM low, Cycle_Start continuous.
- Interrupt_Enable=1, Interrupt_Clear held high across B: Interrupt_Active=1 after B; cleared on the following cycle.
- PWM_DEADTIME_EN, DeadTime=3, edge P=19, Duty=10: PWM high 7 cycles, PWM_N high 7 cycles, 3-cycle gaps, never overlapping.
